cdc_handshake_rx: RTL and testbench
===================================

// Module: cdc_handshake_rx
// PURPOSE
//  Destination-side receiver of the AHB2AHB bridge toggle req/ack CDC handshake. Sits directly downstream of the
//  multi-flop synchronizer: consumes the synchronized request toggle and the quasi-static payload bus.
//  Captures the payload once it is settled, presents it on a valid/ready interface to the destination-side
//  AHB master logic, and returns an acknowledge toggle to the source domain.
// PARAMETERS
//  BUS_WIDTH      66  payload width in bits (addr/data/control bundle)
//  SETTLE_CYCLES  1   extra CLK cycles between detecting the toggle and capturing DATA_IN; legal range 0..255
// PORTS
//  CLK          in   1          destination-domain clock
//  RST          in   1          reset, asynchronous, active-low
//  REQ_TGL      in   1          request toggle, already synchronized to CLK
//  DATA_IN      in   BUS_WIDTH  payload; source holds it stable from before its toggle until ack
//  OUT_READY    in   1          consumer accepts OUT_DATA
//  ERR_CLR      in   1          synchronous clear of ERR_OVERRUN
//  OUT_DATA     out  BUS_WIDTH  captured payload, registered
//  OUT_VALID    out  1          OUT_DATA holds an unconsumed payload
//  ACK_TGL      out  1          acknowledge toggle to source domain (through its own synchronizer), registered
//  BUSY         out  1          FSM not in IDLE
//  ERR_OVERRUN  out  1          sticky; request toggle arrived while not IDLE
// BEHAVIOUR
//  - Reset (RST low, async): state=IDLE, req_prev=0, cnt=0, OUT_DATA=0, OUT_VALID=0, ACK_TGL=0, BUSY=0, ERR_OVERRUN=0.
//  - event = REQ_TGL ^ req_prev; req_prev <= REQ_TGL every cycle.
//    REQ_TGL=1 just after reset counts as an event. Source and receiver share the same reset release.
//  - Counter cnt is 8 bits. FSM states:
//    IDLE:   event in cycle N -> SETTLE, cnt <= SETTLE_CYCLES.
//    SETTLE: cnt!=0 -> cnt <= cnt-1.
//            cnt==0 -> OUT_DATA <= DATA_IN, OUT_VALID <= 1, -> VALID.
//    VALID:  OUT_VALID=1, OUT_DATA held stable. If OUT_READY=1 this cycle: ACK_TGL <= ~ACK_TGL,
//            OUT_VALID <= 0, -> IDLE. Otherwise hold indefinitely.
//  - Latency:
//    DATA_IN is captured at the end of cycle N+1+SETTLE_CYCLES.
//    OUT_VALID first high in cycle N+2+SETTLE_CYCLES.
//    If OUT_READY is high in cycle M, ACK_TGL flips and OUT_VALID drops in cycle M+1.
//  - After an ack, IDLE can detect a new event in the first cycle it is entered. No other gap is required between transfers.
//  - OUT_READY is ignored outside VALID. OUT_VALID never rises without a preceding event.
//  - Overrun: an event while state!=IDLE (SETTLE or VALID, including the VALID&OUT_READY cycle):
//    ERR_OVERRUN <= 1, the event is dropped, and the current transfer completes normally.
//  - ERR_CLR=1 clears ERR_OVERRUN. A simultaneous overrun event wins: ERR_OVERRUN stays 1.
//  - BUSY = (state != IDLE), combinational from the state register.
//  - Reset mid-operation: immediate return to reset values. A partially captured transfer is discarded and no ack is issued.
// TESTING
//  1. Reset: hold RST low with REQ_TGL=0 and random DATA_IN -> all outputs 0. Release -> outputs stay 0 for 20 cycles.
//  2. Single transfer, SETTLE_CYCLES=1, OUT_READY=1: DATA_IN=66'h2_DEAD_BEEF_1234_5678, REQ_TGL 0->1 (event cycle N)
//     -> OUT_VALID=1 and OUT_DATA=66'h2_DEAD_BEEF_1234_5678 in cycle N+3.
//     -> ACK_TGL=1, OUT_VALID=0 in cycle N+4.
//  3. Backpressure: as test 2 with OUT_READY=0 for 10 cycles
//     -> OUT_VALID and OUT_DATA held, ACK_TGL stays 0, BUSY=1.
//     -> OUT_READY=1 -> ACK_TGL flips one cycle later.
//  4. Settle window, SETTLE_CYCLES=2: DATA_IN=A at event cycle N, changed to B in cycle N+2 -> OUT_DATA=B.
//     Change made instead at cycle N+4 -> OUT_DATA=A.
//  5. Overrun: toggle REQ_TGL again while OUT_VALID=1
//     -> ERR_OVERRUN=1, exactly one OUT_VALID transfer, one ACK_TGL flip.
//     -> ERR_CLR=1 for 1 cycle -> ERR_OVERRUN=0.
//  6. Back-to-back: 4 transfers, source toggles REQ_TGL 2 cycles after each ACK_TGL flip
//     -> 4 payloads in order, ACK_TGL ends at 0, ERR_OVERRUN=0.
//     Assert RST low during SETTLE -> OUT_VALID never rises for that transfer.

Source files
------------

// File: rtl/cdc_handshake_rx_if.sv
// Handshake bundle between the CDC synchronizer/payload source and the receiver.
// The receiver takes the slave side of this bundle.
interface cdc_handshake_rx_if #(
    parameter int unsigned BUS_WIDTH = 66
);
    logic                 REQ_TGL;
    logic [BUS_WIDTH-1:0] DATA_IN;
    logic                 OUT_READY;
    logic                 ERR_CLR;
    logic [BUS_WIDTH-1:0] OUT_DATA;
    logic                 OUT_VALID;
    logic                 ACK_TGL;
    logic                 BUSY;
    logic                 ERR_OVERRUN;

    modport master (
        output REQ_TGL, DATA_IN, OUT_READY, ERR_CLR,
        input  OUT_DATA, OUT_VALID, ACK_TGL, BUSY, ERR_OVERRUN
    );

    modport slave (
        input  REQ_TGL, DATA_IN, OUT_READY, ERR_CLR,
        output OUT_DATA, OUT_VALID, ACK_TGL, BUSY, ERR_OVERRUN
    );
endinterface

// File: rtl/cdc_handshake_rx.sv
// Destination side of the toggle req/ack CDC handshake: waits out the payload settle window,
// captures the payload, offers it on valid/ready and returns an ack toggle.
module cdc_handshake_rx #(
    parameter int unsigned BUS_WIDTH     = 66,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input logic               CLK,
    input logic               RST,
    cdc_handshake_rx_if.slave bus
);

    localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES);

    typedef enum logic [1:0] {StIdle, StSettle, StValid} state_e;

    state_e               state_q, state_d;
    logic                 req_prev_q;
    logic [7:0]           cnt_q, cnt_d;
    logic [BUS_WIDTH-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ack_q, ack_d;
    logic                 err_q, err_d;
    logic                 req_evt;

    assign req_evt = bus.REQ_TGL ^ req_prev_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        ack_d   = ack_q;
        unique case (state_q)
            StIdle: begin
                if (req_evt) begin
                    state_d = StSettle;
                    cnt_d   = SETTLE_INIT;
                end
            end
            StSettle: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    data_d  = bus.DATA_IN;
                    valid_d = 1'b1;
                    state_d = StValid;
                end
            end
            StValid: begin
                if (bus.OUT_READY) begin
                    ack_d   = ~ack_q;
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // A new toggle outside IDLE is dropped; setting the flag beats a same-cycle clear.
        err_d = (err_q & ~bus.ERR_CLR) | (req_evt & (state_q != StIdle));
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= StIdle;
            req_prev_q <= 1'b0;
            cnt_q      <= 8'd0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_prev_q <= bus.REQ_TGL;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    assign bus.OUT_DATA    = data_q;
    assign bus.OUT_VALID   = valid_q;
    assign bus.ACK_TGL     = ack_q;
    assign bus.BUSY        = (state_q != StIdle);
    assign bus.ERR_OVERRUN = err_q;

endmodule

// File: tb/tb_cdc_handshake_rx.sv
// Directed bench for cdc_handshake_rx: dut1 uses SETTLE_CYCLES=1, dut2 uses SETTLE_CYCLES=2.
module tb_cdc_handshake_rx;

    logic CLK;
    logic RST;
    int   n_total;
    int   n_bad;

    cdc_handshake_rx_if #(.BUS_WIDTH(66)) bus1 ();
    cdc_handshake_rx_if #(.BUS_WIDTH(66)) bus2 ();

    cdc_handshake_rx #(.BUS_WIDTH(66), .SETTLE_CYCLES(1)) dut1 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus1)
    );

    cdc_handshake_rx #(.BUS_WIDTH(66), .SETTLE_CYCLES(2)) dut2 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    logic [65:0] pay [4];
    logic [65:0] val_a;
    logic [65:0] val_b;
    logic        exp_ack;
    int          waited;
    int          n_xfer;

    initial begin
        n_total = 0;
        n_bad   = 0;
        pay[0]  = 66'h1_0000_0000_0000_0001;
        pay[1]  = 66'h2_ABCD_EF01_2345_6789;
        pay[2]  = 66'h0_FFFF_0000_FFFF_0000;
        pay[3]  = 66'h3_5A5A_A5A5_C3C3_3C3C;
        val_a   = 66'h1_1111_2222_3333_4444;
        val_b   = 66'h2_AAAA_BBBB_CCCC_DDDD;

        // Reset state
        RST            = 1'b0;
        bus1.REQ_TGL   = 1'b0;
        bus1.DATA_IN   = {2'($urandom), $urandom, $urandom};
        bus1.OUT_READY = 1'b0;
        bus1.ERR_CLR   = 1'b0;
        bus2.REQ_TGL   = 1'b0;
        bus2.DATA_IN   = {2'($urandom), $urandom, $urandom};
        bus2.OUT_READY = 1'b0;
        bus2.ERR_CLR   = 1'b0;
        tick();
        tick();
        check("rst_data", bus1.OUT_DATA, 66'h0);
        check("rst_flags", {bus1.OUT_VALID, bus1.ACK_TGL, bus1.BUSY, bus1.ERR_OVERRUN}, 4'h0);
        check("rst_flags2", {bus2.OUT_VALID, bus2.ACK_TGL, bus2.BUSY, bus2.ERR_OVERRUN}, 4'h0);
        RST = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_flags", {bus1.OUT_VALID, bus1.ACK_TGL, bus1.BUSY, bus1.ERR_OVERRUN}, 4'h0);
        end
        check("idle_data", bus1.OUT_DATA, 66'h0);

        // Single transfer, settle 1, ready high
        bus1.DATA_IN   = 66'h2_DEAD_BEEF_1234_5678;
        bus1.OUT_READY = 1'b1;
        bus1.REQ_TGL   = 1'b1;                     // cycle N
        tick();                                    // N+1
        check("single_busy", bus1.BUSY, 1'b1);
        tick();                                    // N+2
        check("single_early", bus1.OUT_VALID, 1'b0);
        tick();                                    // N+3
        check("single_valid", bus1.OUT_VALID, 1'b1);
        check("single_data", bus1.OUT_DATA, 66'h2_DEAD_BEEF_1234_5678);
        check("single_ack_pre", bus1.ACK_TGL, 1'b0);
        tick();                                    // N+4
        check("single_ack", bus1.ACK_TGL, 1'b1);
        check("single_drop", {bus1.OUT_VALID, bus1.BUSY}, 2'b00);

        // Backpressure
        bus1.OUT_READY = 1'b0;
        bus1.DATA_IN   = val_a;
        bus1.REQ_TGL   = 1'b0;
        tick();
        tick();
        tick();
        check("bp_valid", bus1.OUT_VALID, 1'b1);
        bus1.DATA_IN = val_b;                      // source misbehaving: output must hold
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold", {bus1.OUT_VALID, bus1.ACK_TGL, bus1.BUSY}, 3'b111);
            check("bp_data", bus1.OUT_DATA, val_a);
        end
        bus1.OUT_READY = 1'b1;
        tick();
        check("bp_ack", bus1.ACK_TGL, 1'b0);
        check("bp_drop", bus1.OUT_VALID, 1'b0);

        // Settle window, settle 2: change at N+2 is captured, change at N+4 is not
        bus2.OUT_READY = 1'b0;
        bus2.DATA_IN   = val_a;
        bus2.REQ_TGL   = 1'b1;                     // N
        tick();
        tick();                                    // N+2
        bus2.DATA_IN = val_b;
        tick();
        check("win_early", bus2.OUT_VALID, 1'b0);
        tick();                                    // N+4
        check("win_valid", bus2.OUT_VALID, 1'b1);
        check("win_late_chg", bus2.OUT_DATA, val_b);
        bus2.OUT_READY = 1'b1;
        tick();
        check("win_ack", {bus2.ACK_TGL, bus2.OUT_VALID}, 2'b10);
        bus2.OUT_READY = 1'b0;
        bus2.DATA_IN   = val_a;
        bus2.REQ_TGL   = 1'b0;                     // N'
        tick();
        tick();
        tick();
        tick();                                    // N'+4
        bus2.DATA_IN = val_b;
        check("win_valid2", bus2.OUT_VALID, 1'b1);
        check("win_hold_a", bus2.OUT_DATA, val_a);
        tick();
        check("win_hold_a2", bus2.OUT_DATA, val_a);

        // Overrun during VALID
        bus1.OUT_READY = 1'b0;
        bus1.DATA_IN   = pay[1];
        bus1.REQ_TGL   = 1'b1;
        tick();
        tick();
        tick();
        check("ovr_valid", bus1.OUT_VALID, 1'b1);
        check("ovr_err_pre", bus1.ERR_OVERRUN, 1'b0);
        bus1.REQ_TGL = 1'b0;
        tick();
        check("ovr_err", bus1.ERR_OVERRUN, 1'b1);
        check("ovr_data", bus1.OUT_DATA, pay[1]);
        tick();
        bus1.OUT_READY = 1'b1;
        tick();
        check("ovr_ack", {bus1.ACK_TGL, bus1.OUT_VALID}, 2'b10);
        bus1.OUT_READY = 1'b0;
        n_xfer = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus1.OUT_VALID) n_xfer++;
        end
        check("ovr_one_xfer", 66'(n_xfer), 66'd0);
        check("ovr_one_ack", bus1.ACK_TGL, 1'b1);
        check("ovr_sticky", bus1.ERR_OVERRUN, 1'b1);
        bus1.ERR_CLR = 1'b1;
        tick();
        bus1.ERR_CLR = 1'b0;
        check("ovr_clr", bus1.ERR_OVERRUN, 1'b0);

        // Back-to-back from a fresh reset
        RST          = 1'b0;
        bus1.REQ_TGL = 1'b0;
        tick();
        RST = 1'b1;
        tick();
        bus1.OUT_READY = 1'b1;
        exp_ack        = 1'b0;
        n_xfer         = 0;
        for (int i = 0; i < 4; i++) begin
            bus1.DATA_IN = pay[i];
            bus1.REQ_TGL = ~bus1.REQ_TGL;
            waited       = 0;
            tick();
            while (!bus1.OUT_VALID && waited < 10) begin
                tick();
                waited++;
            end
            check("b2b_valid", bus1.OUT_VALID, 1'b1);
            check("b2b_data", bus1.OUT_DATA, pay[i]);
            if (bus1.OUT_VALID) n_xfer++;
            exp_ack = ~exp_ack;
            tick();
            check("b2b_ack", bus1.ACK_TGL, exp_ack);
            tick();
            tick();
        end
        check("b2b_count", 66'(n_xfer), 66'd4);
        check("b2b_ack_end", bus1.ACK_TGL, 1'b0);
        check("b2b_err", bus1.ERR_OVERRUN, 1'b0);

        // Reset during SETTLE discards the transfer
        bus1.DATA_IN = pay[2];
        bus1.REQ_TGL = ~bus1.REQ_TGL;
        tick();
        check("rst_mid_busy", bus1.BUSY, 1'b1);
        RST = 1'b0;
        bus1.REQ_TGL = 1'b0;
        #1;
        check("rst_mid_async", {bus1.BUSY, bus1.OUT_VALID, bus1.ACK_TGL}, 3'b000);
        tick();
        RST = 1'b1;
        n_xfer = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus1.OUT_VALID || bus1.ACK_TGL) n_xfer++;
        end
        check("rst_mid_novalid", 66'(n_xfer), 66'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
